raiz_iter_param: RTL



---
 rtl/raiz_pkg.sv | 14 +
 rtl/raiz_paso.sv | 25 ++
 rtl/raiz_iter_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/raiz_pkg.sv
// rtl/raiz_pkg.sv - shared state encoding and helpers for the iterative square-root unit
package raiz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } raiz_state_e;

    function automatic int clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/raiz_paso.sv
// rtl/raiz_paso.sv - one restoring square-root step: bring down a bit pair, trial-subtract, emit a root bit
module raiz_paso #(
    parameter int RW = 8
) (
    input  logic [RW+1:0] rem,
    input  logic [RW-1:0] root,
    input  logic [1:0]    pair,
    output logic [RW+1:0] rem_n,
    output logic [RW-1:0] root_n
);

    logic [RW+3:0] rem_sh;
    logic [RW+3:0] trial;
    logic          ge;

    // Compare at full width; the kept remainder always fits back into RW+2 bits.
    always_comb begin
        rem_sh = {rem, pair};
        trial  = {2'b00, root, 2'b01};
        ge     = (rem_sh >= trial);
        rem_n  = ge ? (RW+2)'(rem_sh - trial) : rem_sh[RW+1:0];
        root_n = {root[RW-2:0], ge};
    end

endmodule

// File: rtl/raiz_iter_param.sv
// rtl/raiz_iter_param.sv - sequential floor(sqrt) with valid/ready streams; out_rem port under RAIZ_REM_EN
module raiz_iter_param
    import raiz_pkg::*;
#(
    parameter  int W  = 16,
    localparam int RW = W / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_root,
`ifdef RAIZ_REM_EN
    output logic [RW:0]   out_rem,
`endif
    output logic          busy
);

    localparam int CW = clog2(RW);

    if ((W % 2 != 0) || (W < 4)) begin : g_bad_width
        $error("raiz_iter_param: W must be even and >= 4");
    end

    raiz_state_e   state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic [RW+1:0] rem_q, rem_d;
    logic [RW-1:0] root_q, root_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW+1:0] rem_n;
    logic [RW-1:0] root_n;

    raiz_paso #(.RW(RW)) u_paso (
        .rem    (rem_q),
        .root   (root_q),
        .pair   (x_q[W-1:W-2]),
        .rem_n  (rem_n),
        .root_n (root_n)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ITER: begin
                busy   = 1'b1;
                x_d    = {x_q[W-3:0], 2'b00};
                rem_d  = rem_n;
                root_d = root_n;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            // IDLE and the unused code share this branch so a corrupted state recovers as IDLE.
            default: begin
                in_ready = 1'b1;
                state_d  = IDLE;
                if (in_valid) begin
                    x_d     = in_x;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CW'(RW - 1);
                    state_d = ITER;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_root = root_q;
`ifdef RAIZ_REM_EN
    assign out_rem  = rem_q[RW:0];
`endif

endmodule
